// File: rtl/float_params.sv
// Shared single-precision float parameters, FSM state type and word layout
// for the sequential subtractor and the combinational adder.
package float_params;

   localparam int unsigned float_width      = 32;
   localparam int unsigned float_exp_width  = 8;
   localparam int unsigned float_mant_width = 23;
   localparam int unsigned float_bias       = 127;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ALIGN,
      ST_ADD,
      ST_NORM,
      ST_ROUND,
      ST_DONE
   } state_e;

   typedef struct packed {
      logic                        sign;
      logic [float_exp_width-1:0]  exp;
      logic [float_mant_width-1:0] mant;
   } float_t;

endpackage

// File: rtl/float_unpack.sv
// Splits a float word into sign/exponent/mantissa with the hidden bit restored;
// exp==0 words (zero and denormals) are reported as zero with a zero mantissa.
module float_unpack
   import float_params::*;
(
   input  logic [float_width-1:0]      word_i,
   output logic                        sign_o,
   output logic [float_exp_width-1:0]  exp_o,
   output logic [float_mant_width:0]   mant_o,
   output logic                        is_zero_o
);

   float_t f;

   assign f         = float_t'(word_i);
   assign sign_o    = f.sign;
   assign exp_o     = f.exp;
   assign is_zero_o = (f.exp == '0);
   assign mant_o    = is_zero_o ? '0 : {1'b1, f.mant};

endmodule

// File: rtl/float_sub_seq.sv
// Multi-cycle float subtractor (out = a - b) with bit-serial align/normalize.
// Optional round-to-nearest-even stage enabled by defining FLOAT_SUB_ROUND_EN.
module float_sub_seq
   import float_params::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req,
   input  logic [float_width-1:0] a,
   input  logic [float_width-1:0] b,
   output logic                   busy,
   output logic                   ack,
   output logic [float_width-1:0] out
);

   localparam int unsigned MW = float_mant_width + 4;   // hidden + stored + G/R/S
   localparam int unsigned EW = float_exp_width;
   localparam int unsigned DW = 5;
   localparam logic [DW-1:0] DIFF_MAX = DW'(MW);
   localparam logic [EW-1:0] EXP_MAX  = '1;
   localparam logic [EW-1:0] EXP_TOP  = EXP_MAX - EW'(1);

   logic                    a_sign, b_sign, a_zero, b_zero;
   logic [EW-1:0]           a_exp, b_exp;
   logic [float_mant_width:0] a_mant, b_mant;

   float_unpack u_unpack_a (
      .word_i(a), .sign_o(a_sign), .exp_o(a_exp), .mant_o(a_mant), .is_zero_o(a_zero)
   );
   float_unpack u_unpack_b (
      .word_i(b), .sign_o(b_sign), .exp_o(b_exp), .mant_o(b_mant), .is_zero_o(b_zero)
   );

   state_e         state_q;
   logic           busy_q, ack_q;
   logic [float_width-1:0] out_q;
   logic           big_sign_q, small_sign_q, carry_q;
   logic [EW-1:0]  exp_q;
   logic [MW-1:0]  big_m_q, small_m_q;
   logic [DW-1:0]  diff_q;

   // Operand capture: b is negated, larger exponent becomes "big"
   logic           swap_c, cap_big_sign, cap_small_sign;
   logic [EW-1:0]  cap_big_exp, cap_small_exp, exp_gap_c;
   logic [MW-1:0]  cap_big_m, cap_small_m;
   logic [DW-1:0]  cap_diff;

   always_comb begin
      swap_c         = a_zero | (~b_zero & (b_exp > a_exp));
      cap_big_exp    = swap_c ? b_exp : a_exp;
      cap_small_exp  = swap_c ? a_exp : b_exp;
      cap_big_sign   = swap_c ? ~b_sign : a_sign;
      cap_small_sign = swap_c ? a_sign : ~b_sign;
      cap_big_m      = {(swap_c ? b_mant : a_mant), 3'b000};
      cap_small_m    = {(swap_c ? a_mant : b_mant), 3'b000};
      exp_gap_c      = cap_big_exp - cap_small_exp;
      cap_diff       = (exp_gap_c > EW'(MW)) ? DIFF_MAX : DW'(exp_gap_c);
   end

   // Signed-magnitude add of the aligned mantissas
   logic [MW:0] sum_d;
   logic        sum_sign_d, mag_eq_d;

   always_comb begin
      sum_d      = '0;
      sum_sign_d = big_sign_q;
      mag_eq_d   = (big_sign_q != small_sign_q) && (big_m_q == small_m_q);
      if (big_sign_q == small_sign_q) begin
         sum_d = {1'b0, big_m_q} + {1'b0, small_m_q};
      end else if (big_m_q >= small_m_q) begin
         sum_d = {1'b0, big_m_q - small_m_q};
      end else begin
         sum_d      = {1'b0, small_m_q - big_m_q};
         sum_sign_d = small_sign_q;
      end
   end

`ifdef FLOAT_SUB_ROUND_EN
   localparam int unsigned RW = float_mant_width + 2;
   logic          rnd_inc;
   logic [RW-1:0] rnd_sum;

   always_comb begin
      rnd_inc = big_m_q[2] & (big_m_q[1] | big_m_q[0] | big_m_q[3]);
      rnd_sum = {1'b0, big_m_q[MW-1:3]} + RW'(rnd_inc);
   end
`endif

   float_t res_c;

   always_comb begin
      res_c.sign = big_sign_q;
      res_c.exp  = exp_q;
      res_c.mant = big_m_q[MW-2:3];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         busy_q       <= 1'b0;
         ack_q        <= 1'b0;
         out_q        <= '0;
         big_sign_q   <= 1'b0;
         small_sign_q <= 1'b0;
         carry_q      <= 1'b0;
         exp_q        <= '0;
         big_m_q      <= '0;
         small_m_q    <= '0;
         diff_q       <= '0;
      end else begin
         ack_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               // busy_q still high here means this is the ack cycle
               if (busy_q) begin
                  busy_q <= 1'b0;
               end else if (req) begin
                  busy_q       <= 1'b1;
                  big_sign_q   <= cap_big_sign;
                  small_sign_q <= cap_small_sign;
                  exp_q        <= cap_big_exp;
                  big_m_q      <= cap_big_m;
                  small_m_q    <= cap_small_m;
                  carry_q      <= 1'b0;
                  diff_q       <= cap_diff;
                  state_q      <= (cap_diff == '0) ? ST_ADD : ST_ALIGN;
               end
            end
            ST_ALIGN: begin
               small_m_q <= {1'b0, small_m_q[MW-1:2], small_m_q[1] | small_m_q[0]};
               diff_q    <= diff_q - DW'(1);
               if (diff_q == DW'(1)) state_q <= ST_ADD;
            end
            ST_ADD: begin
               if (mag_eq_d) begin
                  big_sign_q <= 1'b0;
                  exp_q      <= '0;
                  big_m_q    <= '0;
                  state_q    <= ST_DONE;
               end else begin
                  big_sign_q <= sum_sign_d;
                  big_m_q    <= sum_d[MW-1:0];
                  carry_q    <= sum_d[MW];
                  state_q    <= ST_NORM;
               end
            end
            ST_NORM: begin
               if (carry_q) begin
                  carry_q <= 1'b0;
                  if (exp_q == EXP_TOP) begin
                     exp_q   <= EXP_MAX;
                     big_m_q <= '0;
                     state_q <= ST_DONE;
                  end else begin
                     exp_q   <= exp_q + EW'(1);
                     big_m_q <= {carry_q, big_m_q[MW-1:2], big_m_q[1] | big_m_q[0]};
                  end
               end else if (!big_m_q[MW-1]) begin
                  // Exponent would reach 0: flush to +0
                  if (exp_q <= EW'(1)) begin
                     big_sign_q <= 1'b0;
                     exp_q      <= '0;
                     big_m_q    <= '0;
                     state_q    <= ST_DONE;
                  end else begin
                     exp_q   <= exp_q - EW'(1);
                     big_m_q <= {big_m_q[MW-2:0], 1'b0};
                  end
               end else begin
`ifdef FLOAT_SUB_ROUND_EN
                  state_q <= ST_ROUND;
`else
                  state_q <= ST_DONE;
`endif
               end
            end
`ifdef FLOAT_SUB_ROUND_EN
            ST_ROUND: begin
               if (rnd_sum[RW-1]) begin
                  if (exp_q == EXP_TOP) begin
                     exp_q   <= EXP_MAX;
                     big_m_q <= '0;
                  end else begin
                     exp_q   <= exp_q + EW'(1);
                     big_m_q <= {1'b1, {(MW-1){1'b0}}};
                  end
               end else begin
                  big_m_q <= {rnd_sum[RW-2:0], 3'b000};
               end
               state_q <= ST_DONE;
            end
`endif
            ST_DONE: begin
               out_q   <= res_c;
               ack_q   <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign ack  = ack_q;
   assign out  = out_q;

endmodule

// File: tb/tb_float_sub_seq.sv
// Directed-vector bench for float_sub_seq: results, ack latency and handshake.
module tb_float_sub_seq;

   logic        clk = 1'b0;
   logic        rst, req, busy, ack;
   logic [31:0] a, b, out;
   int          n_pass  = 0;
   int          n_total = 0;

`ifdef FLOAT_SUB_ROUND_EN
   localparam int          RL      = 1;
   localparam logic [31:0] RND_TIE = 32'h3F800002;
   localparam logic [31:0] RND_UP  = 32'h3F800001;
`else
   localparam int          RL      = 0;
   localparam logic [31:0] RND_TIE = 32'h3F800001;
   localparam logic [31:0] RND_UP  = 32'h3F800000;
`endif

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          lat;   // 0: latency not checked
   } vec_t;

   vec_t vecs [14];

   always #5 clk = ~clk;

   float_sub_seq dut (
      .clk(clk), .rst(rst), .req(req), .a(a), .b(b),
      .busy(busy), .ack(ack), .out(out)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_total++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
   endtask

   // Issue one request and wait (bounded) for ack; lat counts edges after the req edge
   task automatic do_op(input logic [31:0] ai, input logic [31:0] bi,
                        output int lat, output logic [31:0] res);
      a   = ai;
      b   = bi;
      req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      lat = -1;
      res = 'x;
      for (int i = 1; i <= 100 && lat < 0; i++) begin
         @(posedge clk); #1;
         if (ack) begin
            lat = i;
            res = out;
         end
      end
   endtask

   initial begin
      int          lat, n_acks;
      logic [31:0] res, first;

      vecs[0]  = '{32'h40400000, 32'h3F800000, 32'h40000000, 4};
      vecs[1]  = '{32'h3F800000, 32'h3F800000, 32'h00000000, 0};
      vecs[2]  = '{32'h3F800000, 32'hBF800000, 32'h40000000, 4};
      vecs[3]  = '{32'h3F800000, 32'h40000000, 32'hBF800000, 5};
      vecs[4]  = '{32'hBF800000, 32'hBF800000, 32'h00000000, 0};
      vecs[5]  = '{32'h4B800000, 32'h3F800000, 32'h4B7FFFFF, 28};
      vecs[6]  = '{32'h3FC00000, 32'h3FA00000, 32'h3E800000, 5};
      vecs[7]  = '{32'h40A00000, 32'h00000000, 32'h40A00000, 30};
      vecs[8]  = '{32'h00000000, 32'h3F800000, 32'hBF800000, 30};
      vecs[9]  = '{32'h7F000000, 32'hFF000000, 32'h7F800000, 0};
      vecs[10] = '{32'h00800000, 32'h00800001, 32'h00000000, 0};
      vecs[11] = '{32'h3F800001, 32'hB3800000, RND_TIE, 27};
      vecs[12] = '{32'h3F800000, 32'hB3800000, 32'h3F800000, 27};
      vecs[13] = '{32'h3F800000, 32'hB3C00000, RND_UP, 27};

      rst = 1'b1;
      req = 1'b0;
      a   = '0;
      b   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_ack",  32'(ack),  32'd0);
      chk("reset_out",  out,       32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int v = 0; v < 14; v++) begin
         do_op(vecs[v].a, vecs[v].b, lat, res);
         chk($sformatf("vec%0d_out", v), res, vecs[v].res);
         if (vecs[v].lat != 0)
            chk($sformatf("vec%0d_lat", v), 32'(lat), 32'(vecs[v].lat + RL));
         chk($sformatf("vec%0d_busy_ack", v), 32'(busy), 32'd1);
         @(posedge clk); #1;
         chk($sformatf("vec%0d_busy_after", v), 32'(busy), 32'd0);
         chk($sformatf("vec%0d_out_held", v), out, vecs[v].res);
      end

      // req while busy must be ignored
      a   = 32'h40400000;
      b   = 32'h3F800000;
      req = 1'b1;
      @(posedge clk); #1;
      chk("ign_busy", 32'(busy), 32'd1);
      a      = 32'h40A00000;
      b      = 32'h00000000;
      n_acks = 0;
      first  = '0;
      for (int i = 1; i <= 40; i++) begin
         if (i == 3) req = 1'b0;
         @(posedge clk); #1;
         if (ack) begin
            n_acks++;
            if (n_acks == 1) first = out;
         end
      end
      chk("ign_acks", 32'(n_acks), 32'd1);
      chk("ign_out",  first, 32'h40000000);

      // reset in the middle of ALIGN aborts without ack
      a   = 32'h4B800000;
      b   = 32'h3F800000;
      req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ack",  32'(ack),  32'd0);
      chk("rst_out",  out,       32'd0);
      n_acks = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (ack) n_acks++;
      end
      chk("rst_no_ack", 32'(n_acks), 32'd0);

      // back-to-back: new req in the cycle right after ack
      do_op(32'h40400000, 32'h3F800000, lat, res);
      chk("b2b_first_out", res, 32'h40000000);
      @(posedge clk); #1;
      chk("b2b_idle", 32'(busy), 32'd0);
      do_op(32'h3FC00000, 32'h3FA00000, lat, res);
      chk("b2b_second_out", res, 32'h3E800000);
      chk("b2b_second_lat", 32'(lat), 32'(5 + RL));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
